multiplexer_n_to_1_registered: RTL and testbench
================================================

# multiplexer_n_to_1_registered

Parametrised N-to-1, W-bit multiplexer with a registered, handshaked output stage; successor to the fixed 2-to-1 16-bit combinational mux in the datapath. It selects one of N valid/accept input channels, either by an explicit select input or by round-robin arbitration, and presents the result through a one-deep output register with valid/ready flow control. It sits between multi-source producers (register-file read ports, immediate/PC sources, writeback candidates) and a consumer that may stall.

## Interface
Parameters:
- N, 4, number of input channels (2..16)
- W, 16, data width per channel
- SW, $clog2(N) (minimum 1), select/index width

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- MODE  in  1  0 = explicit select via S; 1 = round-robin (only with MUX_RR_EN, else ignored, treated as 0)
- S  in  SW  channel select in MODE 0
- I  in  N*W  flattened channel data; channel k is I[k*W +: W]
- V  in  N  per-channel valid
- A  out  N  per-channel accept (combinational; one-hot or zero)
- Y  out  W  registered output data
- YV  out  1  output valid
- YR  in  1  downstream ready
- YS  out  SW  index of channel held in Y

## Operation
- load = (!YV || YR) && grant_valid. Output register captures on load only.
- MODE 0: grant = S; grant_valid = (S < N) && V[S]. S >= N never grants.
- MODE 1: grant = first k with V[k] set, searching ptr, ptr+1, ..., wrapping modulo N; grant_valid = |V.
- A[grant] = load; all other A bits 0. Transfer on channel k occurs when V[k] && A[k].
- On load: Y <= selected data, YS <= grant, YV <= 1, and in MODE 1 ptr <= (grant+1) mod N (wraps N-1 -> 0).
- YV && YR && !load: YV <= 0; Y and YS hold their last values.
- YV && !YR: Y, YV, YS hold; A = 0 (stall).
- Output transfer and a new load in the same cycle are allowed (full throughput).
- ptr unchanged in MODE 0 and by MODE changes; a MODE switch takes effect on the next grant decision.
- Inputs must hold I[k]/V[k] stable until accepted; the block does not check this.

## Timing
- Reset (async assert, sync deassert by system): Y = 0, YV = 0, YS = 0, ptr = 0; A = 0 while RST is high.
- Latency: input accepted in cycle t -> visible on Y/YV at cycle t+1.
- Throughput: one transfer per cycle when YR is held high.
- A is combinational from V, S, MODE, YV, YR, ptr; no combinational path from I to Y.
- RST mid-transfer: the held word is dropped, YV = 0 immediately, and no A is asserted until RST falls.

## Configuration
- MUX_RR_EN defined: ptr register and round-robin search compiled in; MODE honoured.
- MUX_RR_EN undefined: no ptr, MODE ignored, block behaves as MODE 0 only (registered, handshaked N-to-1 select).

## Structure
- Shared package mux_pkg: MODE encodings (MODE_SEL = 0, MODE_RR = 1), default N/W, SW function (clog2 with minimum 1).
- One sub-module: rr_arbiter_n (V, ptr -> grant, grant_valid), instantiated only under MUX_RR_EN.
- Output register, accept decode, and data select in the top module.

## Test plan
N = 4, W = 16.
- Reset: assert RST with V = 4'hF -> Y = 0, YV = 0, YS = 0, A = 0; release -> first load on the next edge.
- MODE 0: S = 1, V = 4'h2, I1 = 16'h12, YR = 1 -> A = 4'h2; next cycle Y = 16'h12, YS = 1, YV = 1. Then S = 0 with V[0] = 0 -> A = 0, YV falls after the handshake.
- MODE 0 stall: YV = 1, YR = 0, S = 2, V = 4'h4, I2 = 16'h56 -> A = 0 and Y holds for 3 cycles. Raise YR -> same-cycle accept, Y = 16'h56 next cycle.
- Round-robin, MUX_RR_EN: V = 4'hF, I0..I3 = 16'h34, 16'h78, 16'hBC, 16'hF0, YR = 1 -> YS sequence 0, 1, 2, 3, 0 and Y sequence 34, 78, BC, F0, 34. Ptr wraps 3 -> 0.
- Round-robin skip: ptr = 1, V = 4'h9 -> grant 3, then grant 0. S = 3'd? N/A; MODE 0 with S out of range (N = 3 build, S = 3) -> A = 0, no load.
- Reset mid-operation: YV = 1, YR = 0, assert RST -> YV = 0, Y = 0 asynchronously, and no word is delivered after release until a new grant.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the registered N-to-1 multiplexer.
//   MODE_SEL / MODE_RR : encodings of the MODE input
//   DEFAULT_N / DEFAULT_W : default channel count and data width
//   sel_width()        : select/index width, clog2(n) with a minimum of 1
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    localparam int DEFAULT_N = 4;
    localparam int DEFAULT_W = 16;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter: picks the first set V[k], searching from ptr upward
// and wrapping modulo N. Only instantiated when MUX_RR_EN is defined.
//   V           in  N   request vector
//   ptr         in  SW  search start index (always < N)
//   grant       out SW  granted index (0 when nothing requested)
//   grant_valid out 1   any request present
module rr_arbiter_n
    import mux_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int SW = sel_width(N)
) (
    input  logic [N-1:0]  V,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] grant,
    output logic          grant_valid
);

    int idx;

    // Walk offsets from farthest to nearest so the closest request to ptr
    // is the last (and winning) assignment.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = (int'(ptr) + off) % N;
            if (V[idx]) begin
                grant       = SW'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multiplexer_n_to_1_registered.sv
// Parametrised N-to-1, W-bit multiplexer with a one-deep registered output
// stage and valid/ready flow control.
// Optional feature macro: MUX_RR_EN (round-robin selection, MODE honoured).
//   CLK  in  1    clock, rising edge
//   RST  in  1    asynchronous active-high reset
//   MODE in  1    0 = explicit select via S, 1 = round-robin (MUX_RR_EN only)
//   S    in  SW   channel select in MODE 0
//   I    in  N*W  flattened channel data, channel k at I[k*W +: W]
//   V    in  N    per-channel valid
//   A    out N    per-channel accept, combinational, one-hot or zero
//   Y    out W    registered output data
//   YV   out 1    output valid
//   YR   in  1    downstream ready
//   YS   out SW   index of the channel held in Y
module multiplexer_n_to_1_registered
    import mux_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int W  = DEFAULT_W,
    parameter int SW = sel_width(N)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            MODE,
    input  logic [SW-1:0]   S,
    input  logic [N*W-1:0]  I,
    input  logic [N-1:0]    V,
    output logic [N-1:0]    A,
    output logic [W-1:0]    Y,
    output logic            YV,
    input  logic            YR,
    output logic [SW-1:0]   YS
);

    logic [SW-1:0] grant;
    logic          grant_valid;
    logic          sel_valid;
    logic          load;
    logic [W-1:0]  sel_data;

    // Explicit select: S values at or above N match no channel, so they
    // never grant.
    always_comb begin
        sel_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (S == SW'(k)) sel_valid = V[k];
        end
    end

`ifdef MUX_RR_EN
    logic [SW-1:0] ptr;
    logic [SW-1:0] rr_grant;
    logic          rr_valid;

    rr_arbiter_n #(.N(N), .SW(SW)) u_arb (
        .V           (V),
        .ptr         (ptr),
        .grant       (rr_grant),
        .grant_valid (rr_valid)
    );

    always_comb begin
        if (MODE == MODE_RR) begin
            grant       = rr_grant;
            grant_valid = rr_valid;
        end else begin
            grant       = S;
            grant_valid = sel_valid;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr <= '0;
        end else if (load && (MODE == MODE_RR)) begin
            ptr <= (grant == SW'(N - 1)) ? '0 : SW'(grant + 1'b1);
        end
    end
`else
    logic unused_mode;
    assign unused_mode = MODE;

    always_comb begin
        grant       = S;
        grant_valid = sel_valid;
    end
`endif

    // RST gates load so no accept is offered while reset is held.
    assign load = !RST && (!YV || YR) && grant_valid;

    always_comb begin
        A        = '0;
        sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (grant == SW'(k)) begin
                A[k]     = load;
                sel_data = I[k*W +: W];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Y  <= '0;
            YV <= 1'b0;
            YS <= '0;
        end else if (load) begin
            Y  <= sel_data;
            YV <= 1'b1;
            YS <= grant;
        end else if (YR) begin
            YV <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multiplexer_n_to_1_registered.sv
module tb_multiplexer_n_to_1_registered;
    import mux_pkg::*;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int SW = 2;

    logic           CLK = 1'b0;
    logic           RST;
    logic           MODE;
    logic [SW-1:0]  S;
    logic [N*W-1:0] I;
    logic [N-1:0]   V;
    logic [N-1:0]   A;
    logic [W-1:0]   Y;
    logic           YV;
    logic           YR;
    logic [SW-1:0]  YS;

    // Second instance with N = 3 so an out-of-range select can be applied.
    logic           mode3;
    logic [1:0]     s3;
    logic [3*W-1:0] i3;
    logic [2:0]     v3;
    logic [2:0]     a3;
    logic [W-1:0]   y3;
    logic           yv3;
    logic           yr3;
    logic [1:0]     ys3;

    logic [W-1:0] chan [N];

    typedef struct {
        logic [W-1:0]  d;
        logic [SW-1:0] idx;
    } exp_t;
    exp_t q[$];

    int errors = 0;
    int checks = 0;
    bit yv_m;
    int ptr_m;

    multiplexer_n_to_1_registered #(.N(N), .W(W)) u_dut (
        .CLK(CLK), .RST(RST), .MODE(MODE), .S(S), .I(I), .V(V),
        .A(A), .Y(Y), .YV(YV), .YR(YR), .YS(YS)
    );

    multiplexer_n_to_1_registered #(.N(3), .W(W)) u_dut3 (
        .CLK(CLK), .RST(RST), .MODE(mode3), .S(s3), .I(i3), .V(v3),
        .A(a3), .Y(y3), .YV(yv3), .YR(yr3), .YS(ys3)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        I = '0;
        for (int k = 0; k < N; k++) I[k*W +: W] = chan[k];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: which channel the spec says should win this cycle.
    task automatic model_grant(output bit gv, output int g);
        bit rr;
        rr = 1'b0;
`ifdef MUX_RR_EN
        rr = MODE;
`endif
        gv = 1'b0;
        g  = 0;
        if (rr) begin
            for (int off = 0; off < N; off++) begin
                int k;
                k = (ptr_m + off) % N;
                if (!gv && V[k]) begin
                    gv = 1'b1;
                    g  = k;
                end
            end
        end else if (int'(S) < N && V[S]) begin
            gv = 1'b1;
            g  = int'(S);
        end
    endtask

    // One cycle: drive at negedge, check accept, advance model at posedge.
    task automatic step(input logic mode, input logic [SW-1:0] s,
                        input logic [N-1:0] v, input logic yr);
        bit gv;
        int g;
        bit ld;
        bit rr;
        MODE = mode; S = s; V = v; YR = yr;
        #1;
        model_grant(gv, g);
        ld = (!yv_m || yr) && gv;
        check("accept", A, ld ? (64'd1 << g) : 64'd0);
        check("yv", YV, yv_m);
        if (ld) q.push_back('{d: chan[g], idx: SW'(g)});
        rr = 1'b0;
`ifdef MUX_RR_EN
        rr = mode;
`endif
        @(posedge CLK);
        if (ld) begin
            yv_m = 1'b1;
            if (rr) ptr_m = (g + 1) % N;
        end else if (yr) begin
            yv_m = 1'b0;
        end
        @(negedge CLK);
    endtask

    // Monitor: whenever the DUT hands a word downstream, compare it.
    always @(negedge CLK) begin
        exp_t e;
        #2;
        if (!RST && YV && YR) begin
            if (q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_word: got Y=%0h YS=%0d expected none", Y, YS);
            end else begin
                e = q.pop_front();
                check("y", Y, e.d);
                check("ys", YS, e.idx);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; MODE = 1'b0; S = '0; V = 4'hF; YR = 1'b1;
        mode3 = 1'b0; s3 = 2'd3; v3 = 3'b111; yr3 = 1'b1;
        i3 = {16'hC3C3, 16'hB2B2, 16'hA1A1};
        for (int k = 0; k < N; k++) chan[k] = W'(16'h1000 + k);
        yv_m = 1'b0; ptr_m = 0;

        // Reset with all channels valid
        repeat (2) @(negedge CLK);
        #1;
        check("rst_y", Y, 0);
        check("rst_yv", YV, 0);
        check("rst_ys", YS, 0);
        check("rst_a", A, 0);
        @(negedge CLK);
        RST = 1'b0;

        // First load on the first edge after release
        step(1'b0, 2'd0, 4'hF, 1'b1);

        // Explicit select
        chan[1] = 16'h0012;
        step(1'b0, 2'd1, 4'h2, 1'b1);
        step(1'b0, 2'd0, 4'h2, 1'b1);
        step(1'b0, 2'd0, 4'h2, 1'b1);

        // Stall: hold a word with YR low, then release
        chan[3] = 16'h00AB;
        chan[2] = 16'h0056;
        step(1'b0, 2'd3, 4'h8, 1'b0);
        repeat (3) begin
            step(1'b0, 2'd2, 4'h4, 1'b0);
            check("stall_y", Y, 16'h00AB);
        end
        step(1'b0, 2'd2, 4'h4, 1'b1);
        step(1'b0, 2'd0, 4'h0, 1'b1);

        // N=3 instance: S=3 is out of range, S=2 is a positive control
        #1;
        check("oor_a", a3, 0);
        check("oor_yv", yv3, 0);
        s3 = 2'd2; v3 = 3'b100;
        #1;
        check("n3_a", a3, 3'b100);
        @(negedge CLK);
        check("n3_y", y3, 16'hC3C3);
        s3 = 2'd3; v3 = 3'b111;

`ifdef MUX_RR_EN
        // Round-robin sweep with wrap, then skip over idle channels
        chan[0] = 16'h0034; chan[1] = 16'h0078; chan[2] = 16'h00BC; chan[3] = 16'h00F0;
        repeat (5) step(1'b1, 2'd0, 4'hF, 1'b1);
        step(1'b1, 2'd0, 4'h9, 1'b1);
        step(1'b1, 2'd0, 4'h9, 1'b1);
`endif

        // Randomized traffic (MODE also randomized: ignored in the default build)
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++) chan[k] = W'($urandom);
            step(1'($urandom_range(0, 1)), SW'($urandom), N'($urandom),
                 ($urandom_range(0, 3) != 0));
        end

        // Drain
        step(1'b0, 2'd0, 4'h0, 1'b1);
        step(1'b0, 2'd0, 4'h0, 1'b1);
        check("drained", q.size(), 0);

        // Reset while a word is stalled in the output register
        chan[1] = 16'h0077;
        step(1'b0, 2'd1, 4'h2, 1'b0);
        step(1'b0, 2'd0, 4'h0, 1'b0);
        #3;
        V = 4'hF;
        RST = 1'b1;
        #1;
        check("midrst_yv", YV, 0);
        check("midrst_y", Y, 0);
        check("midrst_a", A, 0);
        q.delete();
        yv_m = 1'b0;
        ptr_m = 0;
        @(negedge CLK);
        V = 4'h0;
        RST = 1'b0;
        step(1'b0, 2'd0, 4'h0, 1'b1);
        step(1'b0, 2'd0, 4'h0, 1'b1);
        check("post_rst_yv", YV, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
